// File: rtl/green_cube_pkg.sv
// Shared screen constants, coordinate width and scan FSM states for the
// green-cube game logic.
package green_cube_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int COORD_W  = 10;
    localparam int N_FLOORS = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } scan_state_t;

    // Y that rests a sprite of height h on top of a floor at fy; clamps at the screen top.
    function automatic logic [COORD_W-1:0] snap_above(input logic [COORD_W-1:0] fy,
                                                      input int h);
        if (int'(fy) >= h) begin
            return COORD_W'(int'(fy) - h);
        end
        return '0;
    endfunction

endpackage

// File: rtl/floor_hit_cmp.sv
// Combinational landing test of the player box against one floor segment.
module floor_hit_cmp
    import green_cube_pkg::*;
#(
    parameter int PLAYER_W = 20,
    parameter int PLAYER_H = 20,
    parameter int FLOOR_W  = 100,
    parameter int LAND_TOL = 4
) (
    input  logic               en,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic [COORD_W-1:0] fx,
    input  logic [COORD_W-1:0] fy,
    output logic               hit
);

    localparam int SUM_W = COORD_W + 1;

    logic [SUM_W-1:0] feet_y;
    logic [SUM_W-1:0] top_y;
    logic [SUM_W-1:0] tol_y;
    logic [SUM_W-1:0] right_px;
    logic [SUM_W-1:0] left_px;
    logic [SUM_W-1:0] right_fx;

    // One extra bit keeps edges near 1023 from wrapping.
    always_comb begin
        feet_y   = {1'b0, py} + SUM_W'(PLAYER_H);
        top_y    = {1'b0, fy};
        tol_y    = {1'b0, fy} + SUM_W'(LAND_TOL);
        right_px = {1'b0, px} + SUM_W'(PLAYER_W);
        left_px  = {1'b0, px};
        right_fx = {1'b0, fx} + SUM_W'(FLOOR_W);
        hit = en
            && (feet_y >= top_y) && (feet_y <= tol_y)
            && (right_px > {1'b0, fx}) && (left_px < right_fx);
    end

endmodule

// File: rtl/floor_collide.sv
// Serial floor collision scanner: snapshots player and floors on tick, tests
// one floor per cycle, and reports the highest floor the player lands on.
module floor_collide
    import green_cube_pkg::*;
#(
    parameter int PLAYER_W = 20,
    parameter int PLAYER_H = 20,
    parameter int FLOOR_W  = 100,
    parameter int LAND_TOL = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [COORD_W-1:0] player_x,
    input  logic [COORD_W-1:0] player_y,
    input  logic [COORD_W-1:0] floor_pos_x0,
    input  logic [COORD_W-1:0] floor_pos_x1,
    input  logic [COORD_W-1:0] floor_pos_x2,
    input  logic [COORD_W-1:0] floor_pos_x3,
    input  logic [COORD_W-1:0] floor_pos_x4,
    input  logic [COORD_W-1:0] floor_pos_x5,
    input  logic [COORD_W-1:0] floor_pos_x6,
    input  logic [COORD_W-1:0] floor_pos_x7,
    input  logic [COORD_W-1:0] floor_pos_y0,
    input  logic [COORD_W-1:0] floor_pos_y1,
    input  logic [COORD_W-1:0] floor_pos_y2,
    input  logic [COORD_W-1:0] floor_pos_y3,
    input  logic [COORD_W-1:0] floor_pos_y4,
    input  logic [COORD_W-1:0] floor_pos_y5,
    input  logic [COORD_W-1:0] floor_pos_y6,
    input  logic [COORD_W-1:0] floor_pos_y7,
    input  logic [7:0]         enable,
    output logic               busy,
    output logic               result_valid,
    output logic               on_floor,
    output logic [2:0]         floor_idx,
    output logic [COORD_W-1:0] snap_y,
    output logic               overrun
);

    logic [COORD_W-1:0] fx_in [N_FLOORS];
    logic [COORD_W-1:0] fy_in [N_FLOORS];
    logic [COORD_W-1:0] fx_q  [N_FLOORS];
    logic [COORD_W-1:0] fx_d  [N_FLOORS];
    logic [COORD_W-1:0] fy_q  [N_FLOORS];
    logic [COORD_W-1:0] fy_d  [N_FLOORS];

    scan_state_t        state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [COORD_W-1:0] px_q, px_d;
    logic [COORD_W-1:0] py_q, py_d;
    logic [7:0]         en_q, en_d;
    logic               found_q, found_d;
    logic [COORD_W-1:0] best_fy_q, best_fy_d;
    logic [2:0]         best_idx_q, best_idx_d;
    logic               result_valid_q, result_valid_d;
    logic               on_floor_q, on_floor_d;
    logic [2:0]         floor_idx_q, floor_idx_d;
    logic [COORD_W-1:0] snap_y_q, snap_y_d;
    logic               overrun_q, overrun_d;

    logic               load;
    logic               cur_hit;
    logic               take;
    logic               found_n;
    logic [COORD_W-1:0] fy_n;
    logic [2:0]         idx_n;

    assign fx_in = '{floor_pos_x0, floor_pos_x1, floor_pos_x2, floor_pos_x3,
                     floor_pos_x4, floor_pos_x5, floor_pos_x6, floor_pos_x7};
    assign fy_in = '{floor_pos_y0, floor_pos_y1, floor_pos_y2, floor_pos_y3,
                     floor_pos_y4, floor_pos_y5, floor_pos_y6, floor_pos_y7};

    assign load = tick && (state_q == ST_IDLE);

    generate
        for (genvar gi = 0; gi < N_FLOORS; gi++) begin : g_snap
            always_comb begin
                fx_d[gi] = load ? fx_in[gi] : fx_q[gi];
                fy_d[gi] = load ? fy_in[gi] : fy_q[gi];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    fx_q[gi] <= '0;
                    fy_q[gi] <= '0;
                end else begin
                    fx_q[gi] <= fx_d[gi];
                    fy_q[gi] <= fy_d[gi];
                end
            end
        end
    endgenerate

    floor_hit_cmp #(
        .PLAYER_W (PLAYER_W),
        .PLAYER_H (PLAYER_H),
        .FLOOR_W  (FLOOR_W),
        .LAND_TOL (LAND_TOL)
    ) u_cmp (
        .en  (en_q[cnt_q]),
        .px  (px_q),
        .py  (py_q),
        .fx  (fx_q[cnt_q]),
        .fy  (fy_q[cnt_q]),
        .hit (cur_hit)
    );

    // Strict less-than keeps the earlier (lower) index on equal heights.
    always_comb begin
        take    = cur_hit && (!found_q || (fy_q[cnt_q] < best_fy_q));
        found_n = found_q || cur_hit;
        fy_n    = take ? fy_q[cnt_q] : best_fy_q;
        idx_n   = take ? cnt_q : best_idx_q;
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        px_d           = px_q;
        py_d           = py_q;
        en_d           = en_q;
        found_d        = found_q;
        best_fy_d      = best_fy_q;
        best_idx_d     = best_idx_q;
        result_valid_d = 1'b0;
        on_floor_d     = on_floor_q;
        floor_idx_d    = floor_idx_q;
        snap_y_d       = snap_y_q;
        overrun_d      = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d   = ST_SCAN;
                    cnt_d     = 3'd0;
                    px_d      = player_x;
                    py_d      = player_y;
                    en_d      = enable;
                    found_d   = 1'b0;
                    best_fy_d = '0;
                    best_idx_d = 3'd0;
                end
            end
            ST_SCAN: begin
                if (tick) begin
                    overrun_d = 1'b1;
                end
                cnt_d      = cnt_q + 3'd1;
                found_d    = found_n;
                best_fy_d  = fy_n;
                best_idx_d = idx_n;
                if (cnt_q == 3'd7) begin
                    state_d        = ST_DONE;
                    result_valid_d = 1'b1;
                    on_floor_d     = found_n;
                    if (found_n) begin
                        floor_idx_d = idx_n;
                        snap_y_d    = snap_above(fy_n, PLAYER_H);
                    end
                end
            end
            ST_DONE: begin
                if (tick) begin
                    overrun_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 3'd0;
            px_q           <= '0;
            py_q           <= '0;
            en_q           <= '0;
            found_q        <= 1'b0;
            best_fy_q      <= '0;
            best_idx_q     <= 3'd0;
            result_valid_q <= 1'b0;
            on_floor_q     <= 1'b0;
            floor_idx_q    <= 3'd0;
            snap_y_q       <= '0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            px_q           <= px_d;
            py_q           <= py_d;
            en_q           <= en_d;
            found_q        <= found_d;
            best_fy_q      <= best_fy_d;
            best_idx_q     <= best_idx_d;
            result_valid_q <= result_valid_d;
            on_floor_q     <= on_floor_d;
            floor_idx_q    <= floor_idx_d;
            snap_y_q       <= snap_y_d;
            overrun_q      <= overrun_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign result_valid = result_valid_q;
    assign on_floor     = on_floor_q;
    assign floor_idx    = floor_idx_q;
    assign snap_y       = snap_y_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_floor_collide.sv
// Directed bench for floor_collide with hand-computed landing results.
module tb_floor_collide;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [9:0] px, py;
    logic [9:0] fx [8];
    logic [9:0] fy [8];
    logic [7:0] en;
    logic       busy, result_valid, on_floor, overrun;
    logic [2:0] floor_idx;
    logic [9:0] snap_y;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    floor_collide dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .player_x     (px),
        .player_y     (py),
        .floor_pos_x0 (fx[0]), .floor_pos_x1 (fx[1]), .floor_pos_x2 (fx[2]), .floor_pos_x3 (fx[3]),
        .floor_pos_x4 (fx[4]), .floor_pos_x5 (fx[5]), .floor_pos_x6 (fx[6]), .floor_pos_x7 (fx[7]),
        .floor_pos_y0 (fy[0]), .floor_pos_y1 (fy[1]), .floor_pos_y2 (fy[2]), .floor_pos_y3 (fy[3]),
        .floor_pos_y4 (fy[4]), .floor_pos_y5 (fy[5]), .floor_pos_y6 (fy[6]), .floor_pos_y7 (fy[7]),
        .enable       (en),
        .busy         (busy),
        .result_valid (result_valid),
        .on_floor     (on_floor),
        .floor_idx    (floor_idx),
        .snap_y       (snap_y),
        .overrun      (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic far_floors();
        for (int i = 0; i < 8; i++) begin
            fx[i] = 10'd600;
            fy[i] = 10'd400;
        end
        en = 8'hFF;
    endtask

    // Pulse tick and walk 12 edges (edge 1 samples the tick); the result must
    // appear exactly once, on edge 9.
    task automatic do_scan(input string tag, input logic exp_on, input logic [2:0] exp_idx,
                           input logic [9:0] exp_snap, input bit scramble);
        int nvalid = 0;
        int first  = 0;
        logic [9:0] save_px = px;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        chk({tag, "_busy_start"}, busy, 1);
        for (int k = 2; k <= 12; k++) begin
            @(posedge clk); #1;
            if (scramble && k == 3) begin
                px = 10'd900;
            end
            if (result_valid) begin
                nvalid++;
                first = k;
            end
            if (k == 9) begin
                chk({tag, "_busy_done"}, busy, 1);
                chk({tag, "_on_floor"}, on_floor, exp_on);
                chk({tag, "_floor_idx"}, floor_idx, exp_idx);
                chk({tag, "_snap_y"}, snap_y, exp_snap);
            end
            if (k == 10) begin
                chk({tag, "_busy_idle"}, busy, 0);
            end
        end
        chk({tag, "_valid_count"}, nvalid, 1);
        chk({tag, "_valid_edge"}, first, 9);
        px = save_px;
        $display("scan %s: on_floor=%0d floor_idx=%0d snap_y=%0d", tag, on_floor, floor_idx, snap_y);
    endtask

    initial begin
        int nvalid;
        rst  = 1'b1;
        tick = 1'b0;
        px   = '0;
        py   = '0;
        far_floors();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_valid", result_valid, 0);
        chk("reset_on_floor", on_floor, 0);
        chk("reset_idx", floor_idx, 0);
        chk("reset_snap", snap_y, 0);
        chk("reset_overrun", overrun, 0);

        // Basic landing on floor 1, player moved mid-scan
        px = 10'd160; py = 10'd100;
        fx[1] = 10'd150; fy[1] = 10'd120;
        do_scan("basic", 1'b1, 3'd1, 10'd100, 1'b1);

        // Equal heights: lower index wins
        far_floors();
        fx[2] = 10'd150; fy[2] = 10'd120;
        fx[5] = 10'd140; fy[5] = 10'd120;
        do_scan("tie", 1'b1, 3'd2, 10'd100, 1'b0);

        // Higher floor (smaller y) wins over lower index
        fy[5] = 10'd118;
        do_scan("highest", 1'b1, 3'd5, 10'd98, 1'b0);

        // Disabled floor: no hit, previous idx/snap hold
        far_floors();
        fx[1] = 10'd150; fy[1] = 10'd120;
        en = 8'b1111_1101;
        do_scan("disabled", 1'b0, 3'd5, 10'd98, 1'b0);

        // Horizontal edges against floor 0 at x=150
        far_floors();
        fx[0] = 10'd150; fy[0] = 10'd120;
        px = 10'd250; py = 10'd100;
        do_scan("right_edge", 1'b0, 3'd5, 10'd98, 1'b0);
        px = 10'd131;
        do_scan("left_edge_hit", 1'b1, 3'd0, 10'd100, 1'b0);
        px = 10'd130;
        do_scan("left_edge_miss", 1'b0, 3'd0, 10'd100, 1'b0);

        // Vertical landing window [fy, fy+4]
        px = 10'd160; py = 10'd104; fy[0] = 10'd121;
        do_scan("tol_hit", 1'b1, 3'd0, 10'd101, 1'b0);
        py = 10'd106;
        do_scan("tol_miss", 1'b0, 3'd0, 10'd101, 1'b0);
        py = 10'd100; fy[0] = 10'd121;
        do_scan("above_miss", 1'b0, 3'd0, 10'd101, 1'b0);

        // Near bottom of coordinate range: no wrap
        far_floors();
        fx[3] = 10'd0; fy[3] = 10'd1020;
        px = 10'd0; py = 10'd1000;
        do_scan("no_wrap", 1'b1, 3'd3, 10'd1000, 1'b0);

        // Floor above PLAYER_H: snap saturates at 0
        far_floors();
        fx[4] = 10'd0; fy[4] = 10'd19;
        px = 10'd0; py = 10'd0;
        do_scan("saturate", 1'b1, 3'd4, 10'd0, 1'b0);

        // Second tick while busy: one result, overrun set
        far_floors();
        px = 10'd160; py = 10'd100;
        fx[1] = 10'd150; fy[1] = 10'd120;
        chk("overrun_before", overrun, 0);
        nvalid = 0;
        tick = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            tick = (k == 2);
            if (result_valid) nvalid++;
            if (k == 9) begin
                chk("overrun_idx", floor_idx, 1);
                chk("overrun_snap", snap_y, 100);
            end
        end
        chk("overrun_valid_count", nvalid, 1);
        chk("overrun_flag", overrun, 1);
        $display("overrun: overrun=%0d valid_pulses=%0d", overrun, nvalid);

        // Reset mid-scan: no result, everything cleared
        nvalid = 0;
        tick = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            tick = 1'b0;
            rst  = (k == 4);
            if (result_valid) nvalid++;
        end
        chk("abort_valid_count", nvalid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_on_floor", on_floor, 0);
        chk("abort_idx", floor_idx, 0);
        chk("abort_snap", snap_y, 0);
        chk("abort_overrun", overrun, 0);
        $display("abort: busy=%0d on_floor=%0d overrun=%0d", busy, on_floor, overrun);

        // Tick coincident with reset is ignored
        rst = 1'b1; tick = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; tick = 1'b0;
        chk("rst_tick_busy", busy, 0);
        @(posedge clk); #1;
        chk("rst_tick_busy2", busy, 0);
        $display("rst_tick: busy=%0d", busy);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
